// File: rtl/tcrc_pkg.sv
// Shared definitions for the transmit CAN CRC-15 generator: CRC width and
// polynomial, FSM state encoding and the single-bit CRC step function.
package tcrc_pkg;

  localparam int          CRC_W    = 15;
  localparam logic [14:0] CRC_POLY = 15'h4599;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_SEND = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  // One serial CRC-15 step: feed one data bit into the register.
  function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] crc,
                                                  input logic             b);
    logic nxt;
    nxt = b ^ crc[CRC_W-1];
    return {crc[CRC_W-2:0], 1'b0} ^ (nxt ? CRC_POLY : '0);
  endfunction

endpackage

// File: rtl/tcrc_edge.sv
// Rising-edge detector for a level request line: a held-high level yields
// exactly one single-cycle event. Synchronous active-low reset.
module tcrc_edge (
  input  logic clock,
  input  logic reset,
  input  logic level_i,
  output logic event_o
);

  logic levelQ;

  // Remember the previous level so a new rising edge can be recognised.
  always_ff @(posedge clock) begin
    if (!reset) levelQ <= 1'b0;
    else        levelQ <= level_i;
  end

  assign event_o = level_i & ~levelQ;

endmodule

// File: rtl/tcrc_gen.sv
// Transmit-side CAN CRC-15 generator. Accumulates the CRC over the unstuffed
// frame bits, then shifts it out MSB first on request.
// Optional macro TCRC_SELFTEST_EN adds a receive-style shadow CRC register and
// a selftest_ok output that reports a zero residue once all bits are sent.
module tcrc_gen
  import tcrc_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             bitin,
  input  logic             activ,
  input  logic             send,
  input  logic             shift,
  output logic             crc_bit,
  output logic [CRC_W-1:0] crc_value,
  output logic             busy,
  output logic             crc_done
`ifdef TCRC_SELFTEST_EN
  ,
  output logic             selftest_ok
`endif
);

  logic             actEv;
  logic             shEv;
  logic [1:0]       stateQ,  stateD;
  logic [CRC_W-1:0] crcQ,    crcD;
  logic [CRC_W-1:0] valueQ,  valueD;
  logic [3:0]       cntQ,    cntD;

  tcrc_edge uActivEdge (
    .clock   (clock),
    .reset   (reset),
    .level_i (activ),
    .event_o (actEv)
  );

  tcrc_edge uShiftEdge (
    .clock   (clock),
    .reset   (reset),
    .level_i (shift),
    .event_o (shEv)
  );

  // Next-state logic: accumulate data bits, snapshot on send, shift out bits.
  always_comb begin
    stateD = stateQ;
    crcD   = crcQ;
    valueD = valueQ;
    cntD   = cntQ;
    case (stateQ)
      ST_IDLE, ST_CALC: begin
        if (actEv) begin
          crcD   = crc15_step(crcQ, bitin);
          stateD = ST_CALC;
        end
        if (send) begin
          stateD = ST_SEND;
          valueD = crcD;
          cntD   = 4'd14;
        end
      end
      ST_SEND: begin
        if (shEv) begin
          crcD = {crcQ[CRC_W-2:0], 1'b0};
          if (cntQ == 4'd0) stateD = ST_DONE;
          else              cntD   = cntQ - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // State, CRC, snapshot and bit-counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stateQ <= ST_IDLE;
      crcQ   <= '0;
      valueQ <= '0;
      cntQ   <= 4'd0;
    end else begin
      stateQ <= stateD;
      crcQ   <= crcD;
      valueQ <= valueD;
      cntQ   <= cntD;
    end
  end

  assign busy      = (stateQ == ST_SEND);
  assign crc_done  = (stateQ == ST_DONE);
  assign crc_bit   = busy ? crcQ[CRC_W-1] : 1'b0;
  assign crc_value = valueQ;

`ifdef TCRC_SELFTEST_EN
  logic [CRC_W-1:0] shadowQ, shadowD;
  logic             okQ,     okD;

  // Shadow checker: sees data bits then emitted CRC bits; residue must be 0.
  always_comb begin
    shadowD = shadowQ;
    okD     = okQ;
    if ((stateQ == ST_IDLE || stateQ == ST_CALC) && actEv)
      shadowD = crc15_step(shadowQ, bitin);
    if (stateQ == ST_SEND && shEv) begin
      shadowD = crc15_step(shadowQ, crcQ[CRC_W-1]);
      if (cntQ == 4'd0) okD = (shadowD == '0);
    end
  end

  // Shadow register and sticky self-test result.
  always_ff @(posedge clock) begin
    if (!reset) begin
      shadowQ <= '0;
      okQ     <= 1'b0;
    end else begin
      shadowQ <= shadowD;
      okQ     <= okD;
    end
  end

  assign selftest_ok = okQ;
`endif

endmodule

// File: doc/tcrc_gen.md
Name: tcrc_gen

Overview:
Transmit-side CAN CRC-15 generator; the counterpart of the receive CRC checker in the MAC datapath.
- Accumulates the CRC over the unstuffed frame bits (SOF through data) as the transmit FSM steps them in.
- On request, shifts the 15-bit CRC out MSB first, one bit per shift step, towards the bit stuffer.
- Generator polynomial is x^15+x^14+x^10+x^8+x^7+x^4+x^3+1 (0x4599).

Parameters:
CRC_W, 15, CRC width (fixed by CAN; must not be overridden)
CRC_POLY, 15'h4599, generator polynomial without the x^15 term

Ports:
clock  in  1  system clock, rising edge
reset  in  1  reset, synchronous, active-low
bitin  in  1  current transmit data bit from the transmit FSM
activ  in  1  data-bit step request; level signal, rising edge = one step
send   in  1  level; 1 = stop accumulating and start outputting the CRC
shift  in  1  output step request; level signal, rising edge = advance one CRC bit
crc_bit  out  1  CRC bit currently presented to the stuffer
crc_value  out  15  CRC snapshot taken on SEND entry
busy  out  1  1 while in SEND
crc_done  out  1  1 once all 15 CRC bits have been shifted

Behaviour:
- Reset is sampled on the rising clock edge; while reset=0:
  - state=IDLE, crc register=0, counter=0.
  - activ_q=0, shift_q=0.
  - crc_bit=0, crc_value=0, busy=0, crc_done=0.
- Edge detection, with registered activ_q and shift_q:
  - act_ev = activ & ~activ_q
  - sh_ev = shift & ~shift_q
  - A held-high level produces exactly one event; the register update happens on the same edge the event is detected.
- CRC step, for each act_ev:
  - nxt = bitin ^ crc[14]
  - crc = {crc[13:0],1'b0} ^ (nxt ? CRC_POLY : 0)
  - Arithmetic is mod-2, 15 bits wide; the bit shifted out of the top is discarded.
- State IDLE:
  - act_ev: apply the CRC step, go to CALC.
  - send=1: go to SEND with crc=0 (degenerate empty frame).
  - act_ev and send=1 in the same cycle: apply the step, then go to SEND.
- State CALC:
  - act_ev: apply the CRC step.
  - send=1: go to SEND; load crc_value with the final register value (including any step taken that cycle); counter=14.
  - sh_ev is ignored.
- State SEND:
  - busy=1; crc_bit=crc[14] (combinational from the register).
  - sh_ev: crc <<= 1 with zero fill; counter decrements.
  - sh_ev while counter=0: go to DONE.
  - act_ev is ignored; send is don't-care.
- State DONE:
  - crc_done=1, busy=0, crc_bit=0, crc_value held.
  - All inputs are ignored until reset=0.
- crc_bit=0 in every state except SEND.
- Latency:
  - crc_bit is valid in the first cycle after SEND entry.
  - Each following bit is valid in the cycle after its sh_ev.
- Reset mid-operation (any state) clears everything on the next rising edge. A new frame always requires reset.
- The counter never wraps; it saturates at 0 in DONE.

Optional Feature:
Macro TCRC_SELFTEST_EN.
- Defined:
  - Adds output port selftest_ok (1 bit, reset 0).
  - A second CRC register (receive-style) steps on every act_ev data bit and on every sh_ev with the emitted crc_bit.
  - On DONE entry, selftest_ok=1 if that register equals 0; it holds until reset.
- Not defined: the port and the shadow register do not exist; behaviour is otherwise identical.

Decomposition:
- Shared package tcrc_pkg:
  - CRC_W and CRC_POLY constants.
  - State encoding: IDLE=2'b00, CALC=2'b01, SEND=2'b10, DONE=2'b11.
  - A pure step function crc15_step(crc, bit).
- One natural sub-module, tcrc_edge: the rising-edge detector, instanced twice (activ, shift).
- The self-test shadow register reuses crc15_step; it needs no extra module.

Test Plan:
- Reset held low 3 cycles with activ/send/shift toggling -> all outputs 0, state IDLE.
- Single bit 1 (one activ pulse), then send=1, then 15 shift pulses:
  - crc_value=15'h4599.
  - crc_bit sequence 100010110011001.
  - crc_done=1 after the 15th pulse.
- Bits 1,0 -> crc_value=15'h4EAB; activ held high for 10 cycles counts as one step only.
- send=1 from IDLE with no data -> crc_value=0, 15 zero bits shifted, then crc_done=1; extra shift pulses in DONE change nothing.
- activ pulse arriving in the same cycle as send=1 in CALC -> the step is included in crc_value; activ pulses during SEND leave the bit sequence unchanged.
- reset=0 after 7 shift pulses in SEND -> next cycle busy=0, crc_bit=0, crc_value=0; a fresh frame then produces correct values.
- With TCRC_SELFTEST_EN defined, for any frame above -> selftest_ok=1 at DONE.
